// File: rtl/sprite_pkg.sv
// Shared types for the sprite animator: pose/state enums, animation frame
// encoding, frame base table and the sprite ROM contents.
package sprite_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        MODE_STAND = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_DUCK  = 2'd2,
        MODE_DEAD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_STAND = 2'd0,
        ST_RUN   = 2'd1,
        ST_DUCK  = 2'd2,
        ST_DEAD  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        IDX_STAND  = 3'd0,
        IDX_DEAD   = 3'd1,
        IDX_RUN_L  = 3'd2,
        IDX_RUN_R  = 3'd3,
        IDX_DUCK_L = 3'd4,
        IDX_DUCK_R = 3'd5
    } anim_idx_e;

    // Frame index shown for a given pose and leg phase.
    function automatic logic [2:0] anim_of(input state_e st, input logic leg);
        logic [2:0] idx;
        case (st)
            ST_RUN:  idx = leg ? 3'(IDX_RUN_R)  : 3'(IDX_RUN_L);
            ST_DUCK: idx = leg ? 3'(IDX_DUCK_R) : 3'(IDX_DUCK_L);
            ST_DEAD: idx = 3'(IDX_DEAD);
            default: idx = 3'(IDX_STAND);
        endcase
        return idx;
    endfunction

    // FRAME_BASE table: frames are packed back to back in anim_idx order.
    function automatic int unsigned frame_base(input logic [2:0] idx,
                                               input int unsigned run_sz,
                                               input int unsigned duck_sz);
        int unsigned base;
        case (idx)
            3'(IDX_STAND):  base = 0;
            3'(IDX_DEAD):   base = run_sz;
            3'(IDX_RUN_L):  base = 2 * run_sz;
            3'(IDX_RUN_R):  base = 3 * run_sz;
            3'(IDX_DUCK_L): base = 4 * run_sz;
            default:        base = 4 * run_sz + duck_sz;
        endcase
        return base;
    endfunction

    // ROM contents: {rgb[11:0], alpha[3:0]}; every fourth word is transparent.
    function automatic logic [WORD_W-1:0] rom_word(input logic [15:0] a,
                                                   input int unsigned depth);
        if (32'(a) >= depth) begin
            return '0;
        end
        return {a[11:0] ^ {8'h00, a[15:12]}, (a[1:0] == 2'b00) ? 4'h0 : 4'hF};
    endfunction

endpackage

// File: rtl/sprite_animator_if.sv
// Pixel query / animation control bundle for sprite_animator.
// Optional mirror input exists only when SPRITE_MIRROR_EN is defined.
interface sprite_animator_if;
    logic        frame_tick;
    logic [1:0]  mode;
    logic        pix_valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
`ifdef SPRITE_MIRROR_EN
    logic        mirror;
`endif
    logic        pix_valid_o;
    logic        opaque;
    logic [11:0] rgb;
    logic [2:0]  anim_idx;

`ifdef SPRITE_MIRROR_EN
    modport master (output frame_tick, mode, pix_valid, x, y, pos_x, pos_y, mirror,
                    input  pix_valid_o, opaque, rgb, anim_idx);
    modport slave  (input  frame_tick, mode, pix_valid, x, y, pos_x, pos_y, mirror,
                    output pix_valid_o, opaque, rgb, anim_idx);
`else
    modport master (output frame_tick, mode, pix_valid, x, y, pos_x, pos_y,
                    input  pix_valid_o, opaque, rgb, anim_idx);
    modport slave  (input  frame_tick, mode, pix_valid, x, y, pos_x, pos_y,
                    output pix_valid_o, opaque, rgb, anim_idx);
`endif
endinterface

// File: rtl/sprite_rom.sv
// Synchronous-read sprite ROM, one-cycle latency, all six frames contiguous.
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 47248
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] rdata
);
    logic [15:0]       addr16;
    logic [WORD_W-1:0] rdata_q;

    assign addr16 = 16'(addr);

    // Registered read port.
    always_ff @(posedge clk) begin
        rdata_q <= rom_word(addr16, DEPTH);
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/sprite_animator.sv
// Sprite animator: pose FSM with leg-swap counter plus a 2-stage pixel
// pipeline (hit test / ROM fetch). Define SPRITE_MIRROR_EN for horizontal
// mirroring via a frame-latched mirror input.
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int unsigned RUN_W          = 88,
    parameter int unsigned RUN_H          = 94,
    parameter int unsigned DUCK_W         = 118,
    parameter int unsigned DUCK_H         = 60,
    parameter int unsigned TICKS_PER_STEP = 6,
    parameter int unsigned ADDR_W         = 16
) (
    input logic              clk,
    input logic              rst,
    sprite_animator_if.slave bus
);
    localparam int unsigned RUN_SZ    = RUN_W * RUN_H;
    localparam int unsigned DUCK_SZ   = DUCK_W * DUCK_H;
    localparam int unsigned ROM_DEPTH = 4 * RUN_SZ + 2 * DUCK_SZ;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               leg_q, leg_d;
    logic [2:0]         anim_idx_q, anim_idx_d;
    state_e             req_state;

    logic [COORD_W-1:0] x_e, y_e, px_e, py_e;
    logic [COORD_W-1:0] s1_w_d, s1_h_d, s1_dx_d, s1_dy_d;
    logic [COORD_W-1:0] s1_w_q, s1_h_q, s1_dx_q, s1_dy_q;
    logic               s1_hit_d, s1_hit_q, s1_valid_q;
    logic [ADDR_W-1:0]  s1_base_d, s1_base_q;
    logic               s2_valid_q, s2_hit_q;
    logic [COORD_W-1:0] row_c, col_c;
    logic [ADDR_W-1:0]  rom_addr_c;
    logic [WORD_W-1:0]  rom_word_w;
    logic               opaque_c;

`ifdef SPRITE_MIRROR_EN
    logic mirror_q, mirror_d, s1_mirror_q;
`endif

    assign req_state = state_e'(bus.mode);

    // Pose FSM and leg counter; everything moves only on frame_tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        leg_d   = leg_q;
        if (bus.frame_tick) begin
            if (state_q == ST_DEAD) begin
                state_d = (req_state == ST_STAND) ? ST_STAND : ST_DEAD;
            end else begin
                state_d = req_state;
            end
            if (state_d == ST_RUN || state_d == ST_DUCK) begin
                if (state_d != state_q) begin
                    cnt_d = '0;
                    leg_d = 1'b0;
                end else if (cnt_q == CNT_W'(TICKS_PER_STEP - 1)) begin
                    cnt_d = '0;
                    leg_d = ~leg_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
                leg_d = 1'b0;
            end
        end
        anim_idx_d = anim_of(state_d, leg_d);
    end

`ifdef SPRITE_MIRROR_EN
    // Mirror is a per-frame attribute, latched alongside the pose.
    always_comb begin
        mirror_d = bus.frame_tick ? bus.mirror : mirror_q;
    end
`endif

    // Animation state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_STAND;
            cnt_q      <= '0;
            leg_q      <= 1'b0;
            anim_idx_q <= '0;
`ifdef SPRITE_MIRROR_EN
            mirror_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            leg_q      <= leg_d;
            anim_idx_q <= anim_idx_d;
`ifdef SPRITE_MIRROR_EN
            mirror_q   <= mirror_d;
`endif
        end
    end

    // Stage-1 hit test at 11 bits so a sprite near the right/bottom edge never wraps.
    always_comb begin
        x_e  = COORD_W'(bus.x);
        y_e  = COORD_W'(bus.y);
        px_e = COORD_W'(bus.pos_x);
        py_e = COORD_W'(bus.pos_y);
        if (anim_idx_q == 3'(IDX_DUCK_L) || anim_idx_q == 3'(IDX_DUCK_R)) begin
            s1_w_d = COORD_W'(DUCK_W);
            s1_h_d = COORD_W'(DUCK_H);
        end else begin
            s1_w_d = COORD_W'(RUN_W);
            s1_h_d = COORD_W'(RUN_H);
        end
        s1_hit_d  = (x_e >= px_e) && (x_e < px_e + s1_w_d) &&
                    (y_e >= py_e) && (y_e < py_e + s1_h_d);
        s1_dx_d   = x_e - px_e;
        s1_dy_d   = y_e - py_e;
        s1_base_d = ADDR_W'(frame_base(anim_idx_q, RUN_SZ, DUCK_SZ));
    end

    // Stage-1 registers: the query is bound to the frame selected this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_w_q      <= '0;
            s1_h_q      <= '0;
            s1_dx_q     <= '0;
            s1_dy_q     <= '0;
            s1_base_q   <= '0;
`ifdef SPRITE_MIRROR_EN
            s1_mirror_q <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= bus.pix_valid;
            s1_hit_q    <= s1_hit_d;
            s1_w_q      <= s1_w_d;
            s1_h_q      <= s1_h_d;
            s1_dx_q     <= s1_dx_d;
            s1_dy_q     <= s1_dy_d;
            s1_base_q   <= s1_base_d;
`ifdef SPRITE_MIRROR_EN
            s1_mirror_q <= mirror_q;
`endif
        end
    end

    // ROM address: rows are stored bottom-up within each frame.
    always_comb begin
        row_c = s1_h_q - COORD_W'(1) - s1_dy_q;
`ifdef SPRITE_MIRROR_EN
        col_c = s1_mirror_q ? (s1_w_q - COORD_W'(1) - s1_dx_q) : s1_dx_q;
`else
        col_c = s1_dx_q;
`endif
        rom_addr_c = s1_base_q + ADDR_W'(row_c) * ADDR_W'(s1_w_q) + ADDR_W'(col_c);
    end

    sprite_rom #(
        .ADDR_W (ADDR_W),
        .DEPTH  (ROM_DEPTH)
    ) u_rom (
        .clk   (clk),
        .addr  (rom_addr_c),
        .rdata (rom_word_w)
    );

    // Stage-2 qualifiers travelling alongside the ROM word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_hit_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_hit_q   <= s1_hit_q;
        end
    end

    assign opaque_c        = s2_valid_q & s2_hit_q & (rom_word_w[3:0] == 4'hF);
    assign bus.opaque      = opaque_c;
    assign bus.rgb         = opaque_c ? rom_word_w[WORD_W-1:4] : RGB_W'(0);
    assign bus.pix_valid_o = s2_valid_q;
    assign bus.anim_idx    = anim_idx_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed hit/address table, hand sequences for
// animation and pipeline corner cases, then randomized traffic against a
// behavioural model.
module tb_sprite_animator;
    localparam int TPS = 6;

    logic clk = 1'b0;
    logic rst;
    sprite_animator_if bus();

    sprite_animator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { bit valid; bit opq; int rgb; } exp_t;
    typedef struct { int x; int y; int px; int py; bit hit; int addr; } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t pipe_a, pipe_b;
    int   pose, steps, m_idx;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int rom_rgb(input int a);
        return (a & 'hFFF) ^ ((a >> 12) & 'hF);
    endfunction

    function automatic bit rom_opq(input int a);
        return (a % 4) != 0;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.valid = 0; e.opq = 0; e.rgb = 0;
        return e;
    endfunction

    // Behavioural view of one pixel query against frame idx.
    function automatic exp_t model_pixel(input bit pv, input int idx, input int xx,
                                         input int yy, input int px, input int py);
        exp_t e;
        int w, h, base, addr;
        bit hit;
        e = zero_exp();
        if (!pv) return e;
        e.valid = 1;
        w = (idx >= 4) ? 118 : 88;
        h = (idx >= 4) ? 60 : 94;
        base = 0;
        for (int k = 0; k < idx; k++) base += (k >= 4) ? 118 * 60 : 88 * 94;
        hit = (xx >= px) && (xx < px + w) && (yy >= py) && (yy < py + h);
        if (hit) begin
            addr = (base + (h - 1 - (yy - py)) * w + (xx - px)) % 65536;
            e.opq = rom_opq(addr);
            e.rgb = e.opq ? rom_rgb(addr) : 0;
        end
        return e;
    endfunction

    function automatic void model_reset();
        pose = 0; steps = 0; m_idx = 0;
    endfunction

    // Poses: 0 stand, 1 run, 2 duck, 3 dead; leg follows ticks since entry.
    function automatic void model_tick(input int m);
        int np;
        np = (pose == 3 && m != 0) ? 3 : m;
        if (np == 1 || np == 2) steps = (np != pose) ? 0 : steps + 1;
        pose = np;
        case (pose)
            0: m_idx = 0;
            3: m_idx = 1;
            1: m_idx = 2 + (steps / TPS) % 2;
            default: m_idx = 4 + (steps / TPS) % 2;
        endcase
    endfunction

    task automatic drive(input bit tick, input int m, input bit pv, input int xx,
                         input int yy, input int px, input int py);
        bus.frame_tick = tick;
        bus.mode       = 2'(m);
        bus.pix_valid  = pv;
        bus.x          = 10'(xx);
        bus.y          = 10'(yy);
        bus.pos_x      = 10'(px);
        bus.pos_y      = 9'(py);
`ifdef SPRITE_MIRROR_EN
        bus.mirror     = 1'b0;
`endif
    endtask

    // One cycle: check outputs against the model, then apply new inputs.
    task automatic step(input bit rst_v, input bit tick, input int m, input bit pv,
                        input int xx, input int yy, input int px, input int py);
        exp_t out_exp;
        @(negedge clk);
        out_exp = pipe_b;
        pipe_b  = pipe_a;
        chk("pix_valid_o", int'(bus.pix_valid_o), int'(out_exp.valid));
        chk("opaque", int'(bus.opaque), int'(out_exp.opq));
        chk("rgb", int'(bus.rgb), out_exp.rgb);
        chk("anim_idx", int'(bus.anim_idx), m_idx);
        rst = rst_v;
        drive(tick, m, pv, xx, yy, px, py);
        if (!rst_v) begin
            pipe_a = zero_exp();
            pipe_b = zero_exp();
            model_reset();
        end else begin
            pipe_a = model_pixel(pv, m_idx, xx, yy, px, py);
            if (tick) model_tick(m);
        end
    endtask

    vec_t vecs[14];

    initial begin
        int v, xx, yy, px, py, m, r;
        bit exp_o;

        // x, y, pos_x, pos_y, hit, address (STAND frame, base 0)
        vecs[0]  = '{100, 293, 100, 200, 1, 0};
        vecs[1]  = '{101, 293, 100, 200, 1, 1};
        vecs[2]  = '{188, 293, 100, 200, 0, 0};
        vecs[3]  = '{187, 200, 100, 200, 1, 8271};
        vecs[4]  = '{100, 294, 100, 200, 0, 0};
        vecs[5]  = '{99, 250, 100, 200, 0, 0};
        vecs[6]  = '{150, 199, 100, 200, 0, 0};
        vecs[7]  = '{1023, 0, 1000, 0, 1, 8207};
        vecs[8]  = '{0, 0, 1000, 0, 0, 0};
        vecs[9]  = '{1010, 543, 1000, 450, 1, 10};
        vecs[10] = '{5, 0, 0, 511, 0, 0};
        vecs[11] = '{102, 292, 100, 200, 1, 90};
        vecs[12] = '{187, 293, 100, 200, 1, 87};
        vecs[13] = '{1023, 1023, 1000, 511, 0, 0};

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        pipe_a = zero_exp();
        pipe_b = zero_exp();
        repeat (3) @(negedge clk);
        chk("reset_anim_idx", int'(bus.anim_idx), 0);
        chk("reset_opaque", int'(bus.opaque), 0);
        chk("reset_rgb", int'(bus.rgb), 0);
        chk("reset_pix_valid_o", int'(bus.pix_valid_o), 0);
        rst = 1'b1;

        // Directed hit/address table, streamed one query per cycle.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                exp_o = vecs[i-2].hit && rom_opq(vecs[i-2].addr);
                chk($sformatf("tbl%0d_valid", i - 2), int'(bus.pix_valid_o), 1);
                chk($sformatf("tbl%0d_opaque", i - 2), int'(bus.opaque), int'(exp_o));
                chk($sformatf("tbl%0d_rgb", i - 2), int'(bus.rgb),
                    exp_o ? rom_rgb(vecs[i-2].addr) : 0);
            end
            if (i < 14) drive(0, 0, 1, vecs[i].x, vecs[i].y, vecs[i].px, vecs[i].py);
            else        drive(0, 0, 0, 0, 0, 0, 0);
        end

        // Run cycle: leg swaps every TPS ticks after entry.
        for (int t = 1; t <= 13; t++) begin
            step(1, 1, 1, 0, 0, 0, 0, 0);
            step(1, 0, 1, 0, 0, 0, 0, 0);
            if (t == 1 || t == 7 || t == 13)
                chk($sformatf("run_tick%0d", t), int'(bus.anim_idx), (t == 7) ? 3 : 2);
        end

        // DEAD is sticky until STAND is requested.
        step(1, 1, 3, 0, 0, 0, 0, 0); step(1, 0, 3, 0, 0, 0, 0, 0);
        chk("dead_enter", int'(bus.anim_idx), 1);
        step(1, 1, 1, 0, 0, 0, 0, 0); step(1, 0, 1, 0, 0, 0, 0, 0);
        chk("dead_hold_run", int'(bus.anim_idx), 1);
        step(1, 1, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("dead_exit_stand", int'(bus.anim_idx), 0);
        step(1, 1, 2, 0, 0, 0, 0, 0); step(1, 0, 2, 0, 0, 0, 0, 0);
        chk("duck_enter", int'(bus.anim_idx), 4);

        // Frame switch mid-stream: each query keeps its stage-1 frame.
        step(1, 1, 0, 1, 101, 293, 100, 200);
        step(1, 0, 0, 1, 101, 293, 100, 200);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("switch_old_frame", int'(bus.opaque), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("switch_new_frame", int'(bus.opaque), 1);
        chk("switch_new_rgb", int'(bus.rgb), 1);

        // One-cycle reset while streaming.
        step(1, 0, 0, 1, 101, 293, 100, 200);
        step(1, 0, 0, 1, 101, 293, 100, 200);
        step(0, 0, 0, 1, 101, 293, 100, 200);
        step(1, 0, 0, 1, 101, 293, 100, 200);
        chk("rst_clears_valid", int'(bus.pix_valid_o), 0);
        chk("rst_clears_opaque", int'(bus.opaque), 0);
        step(1, 0, 0, 1, 187, 200, 100, 200);
        chk("rst_discards_inflight", int'(bus.pix_valid_o), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_resume_valid", int'(bus.pix_valid_o), 1);
        chk("rst_resume_rgb", int'(bus.rgb), 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            r  = int'($urandom_range(0, 99));
            m  = int'($urandom_range(0, 3));
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 511));
            v  = px + int'($urandom_range(0, 140)) - 10;
            xx = (v + 1024) % 1024;
            v  = py + int'($urandom_range(0, 110)) - 10;
            yy = (v + 1024) % 1024;
            step((r != 0), ($urandom_range(0, 3) == 0), m, ($urandom_range(0, 3) != 0),
                 xx, yy, px, py);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_animator.md
SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 Parameter RUN_W, 88, width in pixels of stand/run/dead frames.
REQ-002 Parameter RUN_H, 94, height of stand/run/dead frames.
REQ-003 Parameter DUCK_W, 118, width of duck frames.
REQ-004 Parameter DUCK_H, 60, height of duck frames.
REQ-005 Parameter TICKS_PER_STEP, 6, frame_tick pulses between leg swaps; legal range 1..255.
REQ-006 Parameter ADDR_W, 16, sprite ROM address width.
REQ-007 clk  input  1  single system clock; all state on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame.
REQ-010 mode  input  2  requested pose: 0 STAND, 1 RUN, 2 DUCK, 3 DEAD.
REQ-011 pix_valid  input  1  x/y qualify a pixel query this cycle.
REQ-012 x  input  10  scan column; y  input  10  scan row.
REQ-013 pos_x  input  10  sprite left edge; pos_y  input  9  sprite top edge.
REQ-014 pix_valid_o  output  1  pix_valid delayed two cycles.
REQ-015 opaque  output  1  sprite covers the queried pixel.
REQ-016 rgb  output  12  sprite colour; 0 when opaque=0.
REQ-017 anim_idx  output  3  current frame: 0 stand, 1 dead, 2 runL, 3 runR, 4 duckL, 5 duckR.

Function
REQ-018 The FSM SHALL have states STAND, RUN, DUCK, DEAD and update state only on cycles with frame_tick=1.
REQ-019 On frame_tick, STAND/RUN/DUCK SHALL move to the state named by mode; DEAD SHALL be left only when mode=STAND.
REQ-020 A tick counter (8 bits) SHALL count frame_ticks in RUN/DUCK, wrap at TICKS_PER_STEP-1, and toggle leg on wrap.
REQ-021 Entering RUN or DUCK from any other state SHALL clear counter and leg to 0 (leg 0 = L frame).
REQ-022 anim_idx SHALL be a registered function of state and leg, updating the cycle after the frame_tick.
REQ-023 Hit test SHALL be inclusive-exclusive: pos_x <= x < pos_x+W and pos_y <= y < pos_y+H, W/H chosen by anim_idx, computed at 11 bits so no wrap at screen edge.
REQ-024 Address SHALL be FRAME_BASE[anim_idx] + (H-1-(y-pos_y))*W + (x-pos_x), bottom-up row storage, ADDR_W bits.
REQ-025 Stage 1 SHALL register hit, address, anim_idx-derived W/H and pix_valid; stage 2 SHALL register ROM word.
REQ-026 Total latency pix_valid -> pix_valid_o SHALL be exactly 2 cycles, fully pipelined, one query per cycle.
REQ-027 opaque SHALL be stage-1 hit AND ROM word[3:0]==4'hF AND valid; rgb = word[15:4] when opaque, else 0.
REQ-028 A frame_tick concurrent with in-flight queries SHALL NOT alter them; each query uses anim_idx captured at stage 1.
REQ-029 Queries with pix_valid=0 SHALL produce opaque=0, rgb=0.

Reset
REQ-030 While rst=0: state STAND, counter 0, leg 0, anim_idx 0, pipeline valids 0, opaque 0, rgb 0, pix_valid_o 0.
REQ-031 Reset asserted mid-pipeline SHALL discard in-flight queries; first valid output appears 2 cycles after first post-reset pix_valid.

Configuration
REQ-032 Macro SPRITE_MIRROR_EN SHALL, when defined, add input mirror (1 bit) registered on frame_tick; when 1, column term becomes (W-1-(x-pos_x)).
REQ-033 Without SPRITE_MIRROR_EN the port SHALL be absent and addressing per REQ-024 only.

Structure
REQ-034 Package sprite_pkg SHALL hold the mode enum, FSM state enum, anim_idx encoding and FRAME_BASE table.
REQ-035 Sub-module sprite_rom SHALL wrap the synchronous-read 16-bit ROM (1-cycle latency) holding all six frames contiguously.

Verification
REQ-036 mode=RUN, TICKS_PER_STEP=6, 13 frame_ticks -> anim_idx 2 after tick 1, 3 after tick 7, 2 after tick 13.
REQ-037 pos=(100,200), STAND, query x=100,y=293 -> address FRAME_BASE[0]+0, pix_valid_o 2 cycles later; x=188 -> opaque=0.
REQ-038 In RUN set mode=DEAD, tick -> anim_idx 1; mode=RUN, tick -> stays 1; mode=STAND, tick -> 0.
REQ-039 pos_x=1000, query x=1023 -> hit; x=0 -> no hit (no wrap).
REQ-040 Continuous queries, frame_tick mid-stream -> outputs before/after switch use old/new frame exactly per stage-1 capture.
REQ-041 rst low for 1 cycle during streaming -> all outputs 0 next edge, resumes with 2-cycle latency.
